// File: rtl/mod_n_detector.sv
// mod_n_detector: serial divisibility-by-N detector, MSB- or LSB-first per frame, optional bit counter (MODN_BITCNT_EN)
module mod_n_detector #(
   parameter int N = 3,
`ifdef MODN_BITCNT_EN
   parameter int CW = 8,
`endif
   localparam int RW = $clog2(N)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          x,
   input  logic          x_valid,
   input  logic          start,
   input  logic          lsb_first,
   output logic          y,
   output logic          y_valid,
   output logic [RW-1:0] rem
`ifdef MODN_BITCNT_EN
   ,output logic [CW-1:0] bit_cnt
`endif
);
   localparam logic [RW:0] NV = (RW+1)'(N);
   logic [RW-1:0] w, rb, wb, rn, wn;
   logic [RW:0] sm, sl, sw, rs;
   logic mode_q, mode;
   // Next remainder/weight from the frame base; operands stay below N so one subtract wraps
   always_comb begin
      rb   = start ? '0 : rem;
      wb   = start ? RW'(1) : w;
      mode = start ? lsb_first : mode_q;
      sm   = {rb, x};
      sl   = {1'b0, rb} + (x ? {1'b0, wb} : '0);
      sw   = {wb, 1'b0};
      rs   = mode ? sl : sm;
      rn   = RW'(rs >= NV ? rs - NV : rs);
      wn   = mode ? RW'(sw >= NV ? sw - NV : sw) : wb;
   end
   // Registered remainder, weight, frame order and flag; y_valid tracks accepted bits
   always_ff @(posedge clk) begin
      if (reset) begin
         rem     <= '0;
         w       <= RW'(1);
         mode_q  <= 1'b0;
         y       <= 1'b0;
         y_valid <= 1'b0;
      end else begin
         y_valid <= x_valid;
         if (x_valid) begin
            rem    <= rn;
            w      <= wn;
            mode_q <= mode;
            y      <= (rn == '0);
         end
      end
   end
`ifdef MODN_BITCNT_EN
   // Saturating count of bits accepted in the current frame
   always_ff @(posedge clk) begin
      if (reset) bit_cnt <= '0;
      else if (x_valid) bit_cnt <= start ? CW'(1) : (&bit_cnt ? bit_cnt : bit_cnt + 1'b1);
   end
`endif
endmodule

// File: tb/tb_mod_n_detector.sv
// tb_mod_n_detector: directed checks of mod_n_detector for N=3,4,5 (bit counter when MODN_BITCNT_EN)
module tb_mod_n_detector;
   logic clk = 1'b0;
   logic reset = 1'b1, x = 1'b0, x_valid = 1'b0, start = 1'b0, lsb_first = 1'b0;
   logic y3, yv3, y4, yv4, y5, yv5;
   logic [1:0] r3, r4;
   logic [2:0] r5;
   int n_chk = 0, n_fail = 0, pulses = 0;
   logic cnt_en = 1'b0;
`ifdef MODN_BITCNT_EN
   logic [7:0] bc3, bc4, bc5;
   logic [1:0] bcc, rc;
   logic yc, yvc;
`endif

   always #5 clk = ~clk;

   mod_n_detector #(.N(3)) u3 (.clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .start(start),
      .lsb_first(lsb_first), .y(y3), .y_valid(yv3), .rem(r3)
`ifdef MODN_BITCNT_EN
      , .bit_cnt(bc3)
`endif
   );
   mod_n_detector #(.N(4)) u4 (.clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .start(start),
      .lsb_first(lsb_first), .y(y4), .y_valid(yv4), .rem(r4)
`ifdef MODN_BITCNT_EN
      , .bit_cnt(bc4)
`endif
   );
   mod_n_detector #(.N(5)) u5 (.clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .start(start),
      .lsb_first(lsb_first), .y(y5), .y_valid(yv5), .rem(r5)
`ifdef MODN_BITCNT_EN
      , .bit_cnt(bc5)
`endif
   );
`ifdef MODN_BITCNT_EN
   mod_n_detector #(.N(3), .CW(2)) uc (.clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .start(start),
      .lsb_first(lsb_first), .y(yc), .y_valid(yvc), .rem(rc), .bit_cnt(bcc));
`endif

   always @(negedge clk) if (cnt_en && yv5) pulses++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step(input logic b, input logic s, input logic l);
      x = b; start = s; lsb_first = l; x_valid = 1'b1;
      @(posedge clk); #1;
      x_valid = 1'b0; start = 1'b0;
   endtask

   task automatic idle(input int n);
      x_valid = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; x_valid = 1'b0;
   endtask

   initial begin
      #1;
      do_reset();
      chk("rst_rem3", 32'(r3), 0); chk("rst_y3", 32'(y3), 0); chk("rst_yv3", 32'(yv3), 0);
      chk("rst_rem5", 32'(r5), 0); chk("rst_yv5", 32'(yv5), 0);
      // N=3 MSB 1,1,0
      step(1, 1, 0); chk("t1_rem_b0", 32'(r3), 1); chk("t1_y_b0", 32'(y3), 0); chk("t1_yv_b0", 32'(yv3), 1);
      step(1, 0, 0); chk("t1_rem_b1", 32'(r3), 0); chk("t1_y_b1", 32'(y3), 1);
      step(0, 0, 0); chk("t1_rem_b2", 32'(r3), 0); chk("t1_y_b2", 32'(y3), 1); chk("t1_yv_b2", 32'(yv3), 1);
      idle(1); chk("t1_yv_idle", 32'(yv3), 0); chk("t1_y_idle", 32'(y3), 1);
      // N=3 LSB 1,1,0,1
      step(1, 1, 1); chk("t2_rem_b0", 32'(r3), 1); chk("t2_y_b0", 32'(y3), 0);
      step(1, 0, 0); chk("t2_rem_b1", 32'(r3), 0); chk("t2_y_b1", 32'(y3), 1);
      step(0, 0, 0); chk("t2_rem_b2", 32'(r3), 0); chk("t2_y_b2", 32'(y3), 1);
      step(1, 0, 0); chk("t2_rem_b3", 32'(r3), 2); chk("t2_y_b3", 32'(y3), 0);
      // N=5 MSB 1,0,1,0 with 2-cycle gaps; y_valid pulses counted
      do_reset();
      cnt_en = 1'b1;
      step(1, 1, 0); chk("t3_rem_b0", 32'(r5), 1); chk("t3_y_b0", 32'(y5), 0);
      idle(2); chk("t3_yv_gap0", 32'(yv5), 0); chk("t3_rem_gap0", 32'(r5), 1);
      step(0, 0, 0); chk("t3_rem_b1", 32'(r5), 2); chk("t3_y_b1", 32'(y5), 0);
      idle(2);
      step(1, 0, 0); chk("t3_rem_b2", 32'(r5), 0); chk("t3_y_b2", 32'(y5), 1);
      idle(2); chk("t3_y_gap2", 32'(y5), 1); chk("t3_yv_gap2", 32'(yv5), 0);
      step(0, 0, 0); chk("t3_rem_b3", 32'(r5), 0); chk("t3_y_b3", 32'(y5), 1);
      idle(2);
      cnt_en = 1'b0;
      chk("t3_pulses", 32'(pulses), 4);
      // N=3 restart mid-frame, then LSB frame; lsb_first off a start bit is ignored
      step(1, 1, 0); step(0, 0, 0); chk("t4_rem_a", 32'(r3), 2);
      step(1, 1, 0); chk("t4_rem_b", 32'(r3), 1); chk("t4_y_b", 32'(y3), 0);
      step(1, 1, 1); chk("t4_rem_c", 32'(r3), 1);
      step(1, 0, 0); chk("t4_rem_d", 32'(r3), 0); chk("t4_y_d", 32'(y3), 1);
      // one-bit frames back to back
      step(1, 1, 0); step(1, 1, 0); chk("t4_onebit", 32'(r3), 1);
      // N=5 reset mid-frame (x_valid high during reset), then bits without start
      step(1, 1, 0); step(1, 0, 0); chk("t5_rem_pre", 32'(r5), 3);
      x = 1'b1; x_valid = 1'b1; start = 1'b1;
      do_reset(); start = 1'b0;
      chk("t5_yv_rst", 32'(yv5), 0); chk("t5_y_rst", 32'(y5), 0); chk("t5_rem_rst", 32'(r5), 0);
      step(1, 0, 0); chk("t5_rem_b0", 32'(r5), 1);
      step(0, 0, 0); chk("t5_rem_b1", 32'(r5), 2);
      // N=4 MSB 1,1,0,1 -> low two bits; LSB 1,1,1,1 -> weight dies at 0
      step(1, 1, 0); chk("t6_rem_b0", 32'(r4), 1);
      step(1, 0, 0); chk("t6_rem_b1", 32'(r4), 3);
      step(0, 0, 0); chk("t6_rem_b2", 32'(r4), 2); chk("t6_y_b2", 32'(y4), 0);
      step(1, 0, 0); chk("t6_rem_b3", 32'(r4), 1);
      step(0, 1, 0); chk("t6_y_zero", 32'(y4), 1);
      step(1, 1, 1); chk("t7_rem_b0", 32'(r4), 1);
      step(1, 0, 0); chk("t7_rem_b1", 32'(r4), 3);
      step(1, 0, 0); chk("t7_rem_b2", 32'(r4), 3);
      step(1, 0, 0); chk("t7_rem_b3", 32'(r4), 3); chk("t7_y_b3", 32'(y4), 0);
`ifdef MODN_BITCNT_EN
      do_reset(); chk("bc_rst", 32'(bcc), 0);
      step(1, 1, 0); chk("bc_1", 32'(bcc), 1);
      step(0, 0, 0); chk("bc_2", 32'(bcc), 2);
      step(1, 0, 0); chk("bc_3", 32'(bcc), 3);
      step(1, 0, 0); chk("bc_4", 32'(bcc), 3);
      step(0, 0, 0); chk("bc_5", 32'(bcc), 3); chk("bc8_5", 32'(bc3), 5);
      idle(1); chk("bc_hold", 32'(bcc), 3);
      step(1, 1, 0); chk("bc_start", 32'(bcc), 1);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
